module_dac_spi_driver: RTL
==========================

MODULE_DAC_SPI_DRIVER -- requirements
Module: module_dac_spi_driver

Interface
REQ-001 Parameter CLK_DIV, default 4, is the sclk half-period in clk_in cycles; legal range 1..255.
REQ-002 Parameter DAC_CMD, default 4'b0011, is the 4-bit command nibble prepended to every frame.
REQ-003 clk_in  input  1  the single clock; all logic SHALL be clocked on its rising edge.
REQ-004 reset_n  input  1  synchronous, active-low reset.
REQ-005 dac_word  input  12  sample to transmit; sampled on an accepted load edge.
REQ-006 load  input  1  request; the block acts only on its rising edge.
REQ-007 sclk  output  1  serial clock to the DAC; idles low.
REQ-008 sdi  output  1  serial data to the DAC, MSB first.
REQ-009 cs_n  output  1  DAC chip select, active low.
REQ-010 ldac_n  output  1  DAC latch strobe, active low.
REQ-011 busy  output  1  high while a frame or its trailer is in progress.
REQ-012 done  output  1  one-cycle pulse at the end of each frame.
REQ-013 overrun  output  1  one-cycle pulse when a pending word is overwritten.

Function
REQ-014 The block SHALL register load each cycle and detect a rising edge as load high with the previous sample low.
REQ-015 In IDLE, a detected edge in cycle t SHALL capture {DAC_CMD, dac_word} into the 16-bit shift register, enter SHIFT, and drive busy=1 and cs_n=0 from cycle t+1.
REQ-016 Each bit SHALL occupy 2*CLK_DIV cycles: sclk low for CLK_DIV cycles, then high for CLK_DIV cycles.
REQ-017 sdi SHALL hold the current bit for its whole bit period and change only when sclk falls; bit 15 SHALL be on sdi from the first SHIFT cycle.
REQ-018 cs_n SHALL stay low for exactly 32*CLK_DIV cycles.
REQ-019 After the high phase of bit 0, the block SHALL drive cs_n=1 and sclk=0 and enter HOLD for CLK_DIV cycles.
REQ-020 State sequence: IDLE -> SHIFT -> HOLD -> [LDAC] -> IDLE; no other transitions except reset.
REQ-021 done SHALL pulse for one cycle in the last busy cycle; busy SHALL fall in the following cycle.
REQ-022 A load edge while busy SHALL store dac_word in a one-deep pending register and set pending_valid.
REQ-023 If pending_valid is already set when another edge arrives while busy, the new word SHALL replace the old one and overrun SHALL pulse for one cycle.
REQ-024 At frame end with pending_valid set, the block SHALL go directly to SHIFT with the pending word, keep busy high, clear pending_valid, and still pulse done.
REQ-025 A load edge in the same cycle as done SHALL be treated as a busy-time edge and handled under REQ-022..024.
REQ-026 The bit counter SHALL be 4 bits, counting 15 down to 0; the divider counter SHALL be 8 bits and wrap to 0 at CLK_DIV-1.

Reset
REQ-027 With reset_n low at a rising clk_in edge, the block SHALL go to IDLE, drive sclk=0, sdi=0, cs_n=1, ldac_n=1, busy=0, done=0, overrun=0, and clear pending_valid, the counters and the load history.
REQ-028 Reset during a frame SHALL abort it immediately: cs_n goes high in the cycle after the reset edge, with no done pulse and no ldac_n pulse.

Configuration
REQ-029 With DAC_LDAC_PULSE_EN defined, HOLD SHALL be followed by an LDAC state that drives ldac_n=0 for CLK_DIV cycles; busy covers that state, and done pulses in its last cycle.
REQ-030 With DAC_LDAC_PULSE_EN undefined, ldac_n SHALL be tied to 1, the LDAC state SHALL not exist, and done SHALL pulse in the last HOLD cycle.

Structure
REQ-031 A shared package SHALL hold the state encoding constants (IDLE=2'd0, SHIFT=2'd1, HOLD=2'd2, LDAC=2'd3), the frame length (16), and the default DAC_CMD.
REQ-032 The sclk half-period divider SHALL be one sub-module, module_dac_sclk_tick, which produces a one-cycle tick every CLK_DIV cycles while enabled and resets to 0 when disabled.

Verification
REQ-033 CLK_DIV=2, macro undefined, dac_word=12'hA5C, one load edge -> bits 0011_1010_0101_1100 sampled on sclk rising edges, cs_n low for 64 cycles, busy high for 66 cycles, one done pulse.
REQ-034 Same stimulus with the macro defined -> ldac_n low for 2 cycles starting 2 cycles after cs_n rises, busy high for 68 cycles, done in the last ldac_n-low cycle.
REQ-035 Edges with 12'h111 then, while busy, 12'h222 -> two back-to-back frames, cs_n high for exactly 2 cycles between them, busy never falls, overrun never pulses.
REQ-036 While busy, edges with 12'h222 then 12'h333 -> one overrun pulse, and the second frame carries 12'h333.
REQ-037 reset_n low at cycle 20 of a frame -> next cycle cs_n=1, sclk=0, busy=0, no done pulse, and no frame starts until a new load edge.
REQ-038 load held high for 200 cycles -> exactly one frame; CLK_DIV=1 -> sclk toggles every cycle and cs_n is low for 32 cycles.

Source files
------------

// File: rtl/module_dac_spi_driver_pkg.sv
// Shared definitions for the DAC SPI driver: state encoding, frame length
// and the default command nibble.
package module_dac_spi_driver_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2,
        LDAC  = 2'd3
    } state_e;

    localparam int         FRAME_LEN       = 16;
    localparam logic [3:0] DEFAULT_DAC_CMD = 4'b0011;

endpackage

// File: rtl/module_dac_sclk_tick.sv
// Half-period divider for the DAC serial clock: one-cycle tick every CLK_DIV
// cycles while enabled; the count returns to 0 whenever it is disabled.
module module_dac_sclk_tick #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk_in,
    input  logic reset_n,
    input  logic en,
    output logic tick
);

    localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!en || cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/module_dac_spi_driver.sv
// 16-bit SPI frame driver for a DAC with a one-deep pending word buffer.
// Define DAC_LDAC_PULSE_EN to append an active-low LDAC strobe after each frame.
module module_dac_spi_driver
    import module_dac_spi_driver_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4,
    parameter logic [3:0]  DAC_CMD = DEFAULT_DAC_CMD
) (
    input  logic        clk_in,
    input  logic        reset_n,
    input  logic [11:0] dac_word,
    input  logic        load,
    output logic        sclk,
    output logic        sdi,
    output logic        cs_n,
    output logic        ldac_n,
    output logic        busy,
    output logic        done,
    output logic        overrun
);

    localparam logic [3:0] BIT_TOP = 4'(FRAME_LEN - 1);

    state_e                 state_q, state_d;
    logic [FRAME_LEN-1:0]   shreg_q, shreg_d;
    logic [3:0]             bit_cnt_q, bit_cnt_d;
    logic                   sclk_q, sclk_d;
    logic                   load_q;
    logic                   pend_valid_q, pend_valid_d;
    logic [11:0]            pend_word_q, pend_word_d;
    logic                   overrun_q, overrun_d;

    logic        tick;
    logic        busy_int;
    logic        load_edge;
    logic        edge_busy;
    logic        pend_valid_eff;
    logic [11:0] pend_word_eff;
    logic        frame_end;

    module_dac_sclk_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk_in  (clk_in),
        .reset_n (reset_n),
        .en      (busy_int),
        .tick    (tick)
    );

    assign busy_int  = (state_q != IDLE);
    assign load_edge = load && !load_q;
    assign edge_busy = load_edge && busy_int;

    // A busy-time edge is folded into the pending slot before frame end looks
    // at it, so an edge landing on the done cycle still chains the next frame.
    assign pend_valid_eff = pend_valid_q || edge_busy;
    assign pend_word_eff  = edge_busy ? dac_word : pend_word_q;

`ifdef DAC_LDAC_PULSE_EN
    assign frame_end = (state_q == LDAC) && tick;
`else
    assign frame_end = (state_q == HOLD) && tick;
`endif

    // NOTE: every always_comb target gets a default first so no path leaves a latch.
    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        bit_cnt_d    = bit_cnt_q;
        sclk_d       = sclk_q;
        pend_valid_d = pend_valid_eff;
        pend_word_d  = pend_word_eff;
        overrun_d    = edge_busy && pend_valid_q;

        case (state_q)
            IDLE: begin
                if (load_edge) begin
                    state_d   = SHIFT;
                    shreg_d   = {DAC_CMD, dac_word};
                    bit_cnt_d = BIT_TOP;
                    sclk_d    = 1'b0;
                end
            end
            SHIFT: begin
                if (tick) begin
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else begin
                        sclk_d = 1'b0;
                        if (bit_cnt_q == 4'd0) begin
                            state_d = HOLD;
                        end else begin
                            shreg_d   = {shreg_q[FRAME_LEN-2:0], 1'b0};
                            bit_cnt_d = bit_cnt_q - 4'd1;
                        end
                    end
                end
            end
            HOLD: begin
`ifdef DAC_LDAC_PULSE_EN
                if (tick) begin
                    state_d = LDAC;
                end
`endif
            end
            LDAC: begin
`ifndef DAC_LDAC_PULSE_EN
                state_d = IDLE;
`endif
            end
        endcase

        if (frame_end) begin
            if (pend_valid_eff) begin
                state_d      = SHIFT;
                shreg_d      = {DAC_CMD, pend_word_eff};
                bit_cnt_d    = BIT_TOP;
                sclk_d       = 1'b0;
                pend_valid_d = 1'b0;
            end else begin
                state_d = IDLE;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments; reset is synchronous.
    always_ff @(posedge clk_in) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            shreg_q      <= '0;
            bit_cnt_q    <= '0;
            sclk_q       <= 1'b0;
            load_q       <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_word_q  <= '0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            bit_cnt_q    <= bit_cnt_d;
            sclk_q       <= sclk_d;
            load_q       <= load;
            pend_valid_q <= pend_valid_d;
            pend_word_q  <= pend_word_d;
            overrun_q    <= overrun_d;
        end
    end

    assign sclk    = sclk_q;
    assign sdi     = (state_q == SHIFT) && shreg_q[FRAME_LEN-1];
    assign cs_n    = (state_q != SHIFT);
    assign busy    = busy_int;
    assign done    = frame_end;
    assign overrun = overrun_q;

`ifdef DAC_LDAC_PULSE_EN
    assign ldac_n = (state_q != LDAC);
`else
    assign ldac_n = 1'b1;
`endif

endmodule
